arcade_ram_arbiter: RTL and testbench

- Shares the single-port 2 MB Arcade Card RAM between two requesters:
  - the CPU path, i.e. accesses already address-translated by the Arcade Card port logic;
  - the CD-ROM DMA write stream, which fills arcade RAM with sector data.
- Buffers DMA writes in a small FIFO and applies a starvation limit so neither side is locked out.
- Enforces ordering: a CPU access never overtakes a queued DMA write to the same address.
- Drives a variable-latency req/ack memory interface toward the SDRAM controller.

---
 rtl/arcade_ram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_arcade_ram_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_ram_arbiter.sv
// Arbiter for the single-port Arcade Card RAM: CPU accesses vs. a FIFO of CD-ROM DMA writes,
// with a same-address ordering guard, a starvation limit and a req/ack memory port.
//
// state   | meaning
// IDLE    | no access outstanding; arbitrate this cycle
// MEM_CPU | CPU access on the memory port, waiting for MEM_ACK
// MEM_DMA | FIFO head write on the memory port, waiting for MEM_ACK
module arcade_ram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CPU_REQ,
  input  logic        CPU_WE,
  input  logic [20:0] CPU_A,
  input  logic [7:0]  CPU_D,
  output logic [7:0]  CPU_Q,
  output logic        CPU_BUSY,
  input  logic        DMA_WR,
  input  logic [20:0] DMA_A,
  input  logic [7:0]  DMA_D,
  output logic        DMA_FULL,
  output logic        DMA_EMPTY,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [20:0] MEM_A,
  output logic [7:0]  MEM_D,
  input  logic        MEM_ACK,
  input  logic [7:0]  MEM_Q
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEM_CPU = 2'd1,
    MEM_DMA = 2'd2
  } state_t;

  state_t          state;
  logic [20:0]     fifo_a [FIFO_DEPTH];
  logic [7:0]      fifo_d [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic            cpu_we_r;
  logic [20:0]     cpu_a_r;
  logic [7:0]      cpu_d_r;
  logic [SW-1:0]   starve_cnt;

  logic            push;
  logic            pop;
  logic            fifo_ne;
  logic            cpu_cap;
  logic            cpu_want;
  logic            cpu_we_e;
  logic [20:0]     cpu_a_e;
  logic [7:0]      cpu_d_e;
  logic            hazard;
  logic            grant_dma;
  logic            grant_cpu;
  logic [PW-1:0]   off;

  assign push      = DMA_WR & ~DMA_FULL;
  assign pop       = (state == MEM_DMA) & MEM_ACK;
  assign fifo_ne   = (count != '0);
  assign count_nxt = count + CW'(push) - CW'(pop);

  // A request captured this cycle competes immediately, which gives the one-cycle grant latency.
  assign cpu_cap  = CPU_REQ & ~CPU_BUSY;
  assign cpu_want = CPU_BUSY | cpu_cap;
  assign cpu_we_e = CPU_BUSY ? cpu_we_r : CPU_WE;
  assign cpu_a_e  = CPU_BUSY ? cpu_a_r  : CPU_A;
  assign cpu_d_e  = CPU_BUSY ? cpu_d_r  : CPU_D;

  // Only registered entries take part; a push in the same cycle is seen next cycle.
  always_comb begin
    hazard = 1'b0;
    off    = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      off = PW'(i) - rd_ptr;
      if (({1'b0, off} < count) && (fifo_a[i] == cpu_a_e))
        hazard = 1'b1;
    end
  end

  always_comb begin
    grant_dma = 1'b0;
    grant_cpu = 1'b0;
    if (state == IDLE) begin
      if (cpu_want && hazard)
        grant_dma = 1'b1;
      else if ((starve_cnt == SW'(STARVE_MAX)) && fifo_ne)
        grant_dma = 1'b1;
      else if (cpu_want)
        grant_cpu = 1'b1;
      else if (fifo_ne)
        grant_dma = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST && push) begin
      fifo_a[wr_ptr] <= DMA_A;
      fifo_d[wr_ptr] <= DMA_D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      DMA_FULL   <= 1'b0;
      DMA_EMPTY  <= 1'b1;
      CPU_BUSY   <= 1'b0;
      cpu_we_r   <= 1'b0;
      cpu_a_r    <= '0;
      cpu_d_r    <= '0;
      starve_cnt <= '0;
      MEM_REQ    <= 1'b0;
      MEM_WE     <= 1'b0;
      MEM_A      <= '0;
      MEM_D      <= '0;
      CPU_Q      <= 8'hFF;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count     <= count_nxt;
      DMA_FULL  <= (count_nxt == CW'(FIFO_DEPTH));
      DMA_EMPTY <= (count_nxt == '0);

      if (cpu_cap) begin
        CPU_BUSY <= 1'b1;
        cpu_we_r <= CPU_WE;
        cpu_a_r  <= CPU_A;
        cpu_d_r  <= CPU_D;
      end

      if (!fifo_ne)
        starve_cnt <= '0;
      else if (grant_dma)
        starve_cnt <= '0;
      else if (grant_cpu && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + SW'(1);

      case (state)
        IDLE: begin
          if (grant_dma) begin
            MEM_REQ <= 1'b1;
            MEM_WE  <= 1'b1;
            MEM_A   <= fifo_a[rd_ptr];
            MEM_D   <= fifo_d[rd_ptr];
            state   <= MEM_DMA;
          end else if (grant_cpu) begin
            MEM_REQ <= 1'b1;
            MEM_WE  <= cpu_we_e;
            MEM_A   <= cpu_a_e;
            MEM_D   <= cpu_d_e;
            state   <= MEM_CPU;
          end
        end
        MEM_CPU: begin
          if (MEM_ACK) begin
            MEM_REQ  <= 1'b0;
            CPU_BUSY <= 1'b0;
            if (!MEM_WE)
              CPU_Q <= MEM_Q;
            state <= IDLE;
          end
        end
        MEM_DMA: begin
          if (MEM_ACK) begin
            MEM_REQ <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arcade_ram_arbiter.sv
// Scoreboard bench for arcade_ram_arbiter: a queue-based reference model predicts every memory
// access and the per-cycle status outputs; an independent monitor pops and compares.
module tb_arcade_ram_arbiter;
  localparam int DEPTH = 4;
  localparam int SMAX  = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CPU_REQ = 1'b0;
  logic        CPU_WE = 1'b0;
  logic [20:0] CPU_A = '0;
  logic [7:0]  CPU_D = '0;
  logic [7:0]  CPU_Q;
  logic        CPU_BUSY;
  logic        DMA_WR = 1'b0;
  logic [20:0] DMA_A = '0;
  logic [7:0]  DMA_D = '0;
  logic        DMA_FULL;
  logic        DMA_EMPTY;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [20:0] MEM_A;
  logic [7:0]  MEM_D;
  logic        MEM_ACK = 1'b0;
  logic [7:0]  MEM_Q = '0;

  arcade_ram_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .RST(RST),
    .CPU_REQ(CPU_REQ), .CPU_WE(CPU_WE), .CPU_A(CPU_A), .CPU_D(CPU_D),
    .CPU_Q(CPU_Q), .CPU_BUSY(CPU_BUSY),
    .DMA_WR(DMA_WR), .DMA_A(DMA_A), .DMA_D(DMA_D),
    .DMA_FULL(DMA_FULL), .DMA_EMPTY(DMA_EMPTY),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_A(MEM_A), .MEM_D(MEM_D),
    .MEM_ACK(MEM_ACK), .MEM_Q(MEM_Q)
  );

  always #5 CLK = ~CLK;

  typedef struct packed { logic we; logic [20:0] a; logic [7:0] d; } acc_t;
  typedef struct packed { logic req; logic busy; logic full; logic empty; logic [7:0] q; logic z; } exp_t;

  acc_t acc_q[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  // reference model state
  int         m_state = 0;   // 0 idle, 1 cpu access, 2 dma access
  int         m_cnt = 0;
  acc_t       mq[$];
  bit         mp = 0;
  acc_t       mcpu;
  int         starve = 0;
  logic [7:0] q_last = 8'hFF;
  logic [7:0] ref_mem [int];
  logic [7:0] sdram [int];
  bit         hold_ack = 0;
  bit         stray_en = 0;
  int         lat_fix = -1;

  function automatic logic [7:0] init_val(logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_rd(logic [20:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
  endfunction

  function automatic logic [7:0] sd_rd(logic [20:0] a);
    return sdram.exists(int'(a)) ? sdram[int'(a)] : init_val(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: compares DUT outputs against whatever the model queued
  initial begin
    logic req_prev;
    exp_t e;
    acc_t x;
    req_prev = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL exp_queue actual=empty expected=entry t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("mem_req",   32'(MEM_REQ),   32'(e.req));
          chk("cpu_busy",  32'(CPU_BUSY),  32'(e.busy));
          chk("dma_full",  32'(DMA_FULL),  32'(e.full));
          chk("dma_empty", 32'(DMA_EMPTY), 32'(e.empty));
          chk("cpu_q",     32'(CPU_Q),     32'(e.q));
          if (e.z) begin
            chk("rst_mem_we", 32'(MEM_WE), 32'(0));
            chk("rst_mem_a",  32'(MEM_A),  32'(0));
            chk("rst_mem_d",  32'(MEM_D),  32'(0));
          end
        end
        if (MEM_REQ && !req_prev) begin
          if (acc_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_access actual_a=%0h expected=none t=%0t", MEM_A, $time);
          end else begin
            x = acc_q.pop_front();
            chk("acc_we", 32'(MEM_WE), 32'(x.we));
            chk("acc_a",  32'(MEM_A),  32'(x.a));
            chk("acc_d",  32'(MEM_D),  32'(x.d));
          end
        end
      end
      req_prev = MEM_REQ;
    end
  end

  task automatic new_lat();
    m_cnt = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 4));
  endtask

  // one clock of stimulus; the model predicts the state after the coming edge
  task automatic step(input bit creq, input bit cwe, input logic [20:0] ca, input logic [7:0] cd,
                      input bit dwr, input logic [20:0] da, input logic [7:0] dd,
                      input bit rst, input bit fack);
    bit ack, push, cap, want, haz, gd, gc;
    acc_t ce;
    exp_t e;
    int sz;
    @(negedge CLK);
    ack = 1'b0;
    if (fack) ack = 1'b1;
    else if (m_state != 0 && !hold_ack) begin
      if (m_cnt == 0) ack = 1'b1;
      else m_cnt--;
    end else if (m_state == 0 && stray_en && $urandom_range(0, 15) == 0) ack = 1'b1;
    MEM_Q = 8'($urandom);
    if (ack && MEM_REQ) begin
      if (MEM_WE) sdram[int'(MEM_A)] = MEM_D;
      else MEM_Q = sd_rd(MEM_A);
    end
    RST = rst; CPU_REQ = creq; CPU_WE = cwe; CPU_A = ca; CPU_D = cd;
    DMA_WR = dwr; DMA_A = da; DMA_D = dd; MEM_ACK = ack;

    if (rst) begin
      m_state = 0; m_cnt = 0; mq.delete(); mp = 0; starve = 0; q_last = 8'hFF;
    end else begin
      sz   = mq.size();
      push = dwr && (sz < DEPTH);
      cap  = creq && !mp;
      if (mp) ce = mcpu;
      else begin ce.we = cwe; ce.a = ca; ce.d = cd; end
      gd = 0; gc = 0;
      if (m_state == 0) begin
        want = mp || cap;
        haz = 0;
        foreach (mq[i]) if (want && mq[i].a == ce.a) haz = 1;
        if (haz) gd = 1;
        else if (starve == SMAX && sz > 0) gd = 1;
        else if (want) gc = 1;
        else if (sz > 0) gd = 1;
        if (gd) begin acc_q.push_back(mq[0]); m_state = 2; new_lat(); end
        else if (gc) begin acc_q.push_back(ce); m_state = 1; new_lat(); end
      end else if (ack) begin
        if (m_state == 2) begin
          ref_mem[int'(mq[0].a)] = mq[0].d;
          void'(mq.pop_front());
        end else begin
          if (mcpu.we) ref_mem[int'(mcpu.a)] = mcpu.d;
          else q_last = ref_rd(mcpu.a);
          mp = 0;
        end
        m_state = 0;
      end
      if (sz == 0) starve = 0;
      else if (gd) starve = 0;
      else if (gc && starve < SMAX) starve++;
      if (push) mq.push_back({1'b1, da, dd});
      if (cap) begin mp = 1; mcpu = ce; end
    end
    e.req = (m_state != 0); e.busy = mp; e.full = (mq.size() == DEPTH);
    e.empty = (mq.size() == 0); e.q = q_last; e.z = rst;
    exp_q.push_back(e);
    mon_en = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 21'h0, 8'h0, 0, 21'h0, 8'h0, 0, 0);
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (m_state == 0 && mq.size() == 0 && !mp) done = 1;
      else idle(1);
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=busy expected=idle t=%0t", $time);
    end
    idle(2);
  endtask

  initial begin
    sdram[21'h012345] = 8'h5A;
    ref_mem[21'h012345] = 8'h5A;

    repeat (3) step(0, 0, 21'h0, 8'h0, 0, 21'h0, 8'h0, 1, 0);
    idle(2);

    // CPU read, ack three cycles after MEM_REQ rises
    lat_fix = 3;
    step(1, 0, 21'h012345, 8'h00, 0, 21'h0, 8'h0, 0, 0);
    drain();

    // five back-to-back DMA pushes with acks held off; fifth is dropped
    lat_fix = 2; hold_ack = 1;
    for (int i = 0; i < 5; i++)
      step(0, 0, 21'h0, 8'h0, 1, 21'(32'h200 + i), 8'(8'h30 + i), 0, 0);
    idle(3);
    hold_ack = 0;
    drain();

    // ordering guard: CPU read of an address still sitting in the FIFO
    hold_ack = 1; lat_fix = 1;
    step(0, 0, 21'h0, 8'h0, 1, 21'h000280, 8'h11, 0, 0);
    idle(1);
    step(0, 0, 21'h0, 8'h0, 1, 21'h000100, 8'h77, 0, 0);
    step(1, 0, 21'h000100, 8'h00, 0, 21'h0, 8'h0, 0, 0);
    idle(2);
    hold_ack = 0;
    drain();

    // starvation limit under continuous CPU requests
    lat_fix = 1;
    step(0, 0, 21'h0, 8'h0, 1, 21'h000300, 8'h99, 0, 0);
    for (int i = 0; i < 14; i++)
      step(1, 0, 21'(32'h180 + i), 8'h00, 0, 21'h0, 8'h0, 0, 0);
    drain();

    // request while busy is ignored
    lat_fix = 3;
    step(1, 0, 21'h000040, 8'h00, 0, 21'h0, 8'h0, 0, 0);
    step(1, 1, 21'h000041, 8'hEE, 0, 21'h0, 8'h0, 0, 0);
    step(1, 1, 21'h000042, 8'hEF, 0, 21'h0, 8'h0, 0, 0);
    drain();

    // reset during a CPU access, then a late ack
    hold_ack = 1;
    step(1, 0, 21'h000050, 8'h00, 0, 21'h0, 8'h0, 0, 0);
    idle(2);
    step(0, 0, 21'h0, 8'h0, 0, 21'h0, 8'h0, 1, 0);
    hold_ack = 0;
    idle(1);
    step(0, 0, 21'h0, 8'h0, 0, 21'h0, 8'h0, 0, 1);
    idle(3);

    // randomized traffic with overlapping address pools and stray acks
    lat_fix = -1; stray_en = 1;
    for (int i = 0; i < 2500; i++) begin
      bit creq, cwe, dwr;
      logic [20:0] ca, da;
      creq = ($urandom_range(0, 2) == 0);
      cwe  = $urandom_range(0, 1) == 1;
      ca   = ($urandom_range(0, 7) == 0) ? 21'($urandom) : 21'(32'h100 + $urandom_range(0, 7));
      dwr  = (i % 500 < 250) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0);
      da   = 21'(32'h100 + $urandom_range(0, 7));
      step(creq, cwe, ca, 8'($urandom), dwr, da, 8'($urandom), 0, 0);
    end
    stray_en = 0;
    drain();

    @(posedge CLK);
    #2;
    mon_en = 0;
    chk("acc_queue_left", 32'(acc_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
